// File: rtl/nfa_pkg.sv
// Shared defaults and the class-field helper used by the NFA chain engine.
package nfa_pkg;

  localparam int unsigned CLS_W_DEF    = 6;
  localparam int unsigned OFF_W_DEF    = 16;
  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned NL_CLASS_DEF = 0;
  // Widest STATE_CLASS vector supported (64 states x 8-bit class index)
  localparam int unsigned SC_MAX_W     = 512;

  function automatic int unsigned class_field(input logic [SC_MAX_W-1:0] sc,
                                              input int unsigned         idx,
                                              input int unsigned         w);
    logic [SC_MAX_W-1:0] sh;
    sh = sc >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/nfa_chain_engine_cell.sv
// One NFA position: state flop gated by its class bit, fed by start/prev/loop/skip.
module nfa_state_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic sod_i,
  input  logic m_i,
  input  logic start_i,
  input  logic prev_i,
  input  logic loop_i,
  input  logic skip_i,
  output logic next_o,
  output logic state_o
);

  logic state_q;

  // start_i is not history, so it survives the sod clear
  always_comb next_o = m_i & (start_i | (~sod_i & (prev_i | loop_i | skip_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state_q <= 1'b0;
    else if (en_i) state_q <= next_o;
  end

  assign state_o = state_q;

endmodule

// File: rtl/nfa_chain_engine.sv
// Parametrised payload NFA with sticky/pulse match outputs.
// Per-stream statistics are built only when NFA_MATCH_STATS_EN is defined.
module nfa_chain_engine
  import nfa_pkg::*;
#(
  parameter int unsigned                 NUM_STATES  = 24,
  parameter int unsigned                 NUM_CLASSES = 34,
  parameter int unsigned                 CLS_W       = CLS_W_DEF,
  parameter logic [NUM_STATES*CLS_W-1:0] STATE_CLASS = '0,
  parameter logic [NUM_STATES-1:0]       LOOP_MASK   = '0,
  parameter logic [NUM_STATES-1:0]       SKIP_MASK   = '0,
  parameter bit                          ANCHORED    = 1'b1,
  parameter bit                          MULTILINE   = 1'b1,
  parameter int unsigned                 NL_CLASS    = NL_CLASS_DEF,
  parameter int unsigned                 OFF_W       = OFF_W_DEF,
  parameter int unsigned                 CNT_W       = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sod,
  input  logic [NUM_CLASSES-1:0] class_in,
  output logic                   out,
  output logic                   match_pulse,
  output logic [CNT_W-1:0]       match_count,
  output logic [OFF_W-1:0]       first_off,
  output logic                   first_vld
);

  logic [NUM_STATES-1:0] state_w;
  logic [NUM_STATES-1:0] next_w;
  logic                  s_w;
  logic                  hit;
  logic                  out_q, pulse_q, started_q, nl_q;

  always_comb begin
    s_w = 1'b1;
    if (ANCHORED) s_w = sod | (MULTILINE & started_q & nl_q);
  end

  for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_st
    localparam int unsigned CI = class_field(SC_MAX_W'(STATE_CLASS), gi, CLS_W);
    logic start_w, prev_w, skip_w;
    if (gi == 0) begin : g_head
      assign start_w = s_w;
      assign prev_w  = 1'b0;
    end else begin : g_body
      assign start_w = 1'b0;
      assign prev_w  = state_w[gi-1];
    end
    if (gi >= 2 && SKIP_MASK[gi]) begin : g_skip
      assign skip_w = state_w[gi-2];
    end else begin : g_noskip
      assign skip_w = 1'b0;
    end
    nfa_state_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .sod_i   (sod),
      .m_i     (class_in[CI]),
      .start_i (start_w),
      .prev_i  (prev_w),
      .loop_i  (LOOP_MASK[gi] & state_w[gi]),
      .skip_i  (skip_w),
      .next_o  (next_w[gi]),
      .state_o (state_w[gi])
    );
  end

  assign hit = next_w[NUM_STATES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= 1'b0;
      pulse_q   <= 1'b0;
      started_q <= 1'b0;
      nl_q      <= 1'b0;
    end else if (en) begin
      pulse_q   <= hit;
      out_q     <= hit | (out_q & ~sod);
      started_q <= started_q | sod;
      nl_q      <= class_in[NL_CLASS];
    end else begin
      pulse_q   <= 1'b0;
    end
  end

  assign out         = out_q;
  assign match_pulse = pulse_q;

  logic unused_ok;
  assign unused_ok = ^{class_in, started_q, nl_q, state_w};

`ifdef NFA_MATCH_STATS_EN
  logic [OFF_W-1:0] off_q, off_d, cur_off, foff_q, foff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
  logic             vld_q, vld_d, base_vld;

  // sod restarts the stats first, then this byte's hit is applied on top
  always_comb begin
    off_d    = off_q;
    cnt_d    = cnt_q;
    foff_d   = foff_q;
    vld_d    = vld_q;
    cur_off  = sod ? '0 : off_q;
    base_cnt = sod ? '0 : cnt_q;
    base_vld = sod ? 1'b0 : vld_q;
    if (en) begin
      if (sod)             off_d = OFF_W'(1);
      else if (off_q != '1) off_d = off_q + OFF_W'(1);
      cnt_d = (hit && base_cnt != '1) ? base_cnt + CNT_W'(1) : base_cnt;
      vld_d = base_vld | hit;
      if (hit && !base_vld) foff_d = cur_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      cnt_q  <= '0;
      foff_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      off_q  <= off_d;
      cnt_q  <= cnt_d;
      foff_q <= foff_d;
      vld_q  <= vld_d;
    end
  end

  assign match_count = cnt_q;
  assign first_off   = foff_q;
  assign first_vld   = vld_q;
`else
  assign match_count = '0;
  assign first_off   = '0;
  assign first_vld   = 1'b0;
`endif

endmodule
